// File: rtl/keypad_emulator.sv
// Presses one key of the 4x6 matrix: bounce-in, hold, bounce-out, gap; one request at a time, busy blocks new ones.
// kpcol follows kprow combinationally; contact/done/err are registered and change one cycle after the deciding edge.
module keypad_emulator #(
  parameter int unsigned HOLD_CYCLES   = 100000,
  parameter int unsigned BOUNCE_CYCLES = 5000,
  parameter int unsigned BOUNCE_PERIOD = 250,
  parameter int unsigned GAP_CYCLES    = 100000
) (
  input  logic       clk5,
  input  logic       rstPBn,
  input  logic       press_req,
  input  logic [1:0] press_row,
  input  logic [2:0] press_col,
  input  logic [3:0] kprow,
  output logic [5:0] kpcol,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       contact
);

  typedef enum logic [2:0] {
    S_IDLE, S_BOUNCE_IN, S_HOLD, S_BOUNCE_OUT, S_GAP
  } state_e;

  localparam logic [19:0] HOLD_LD   = 20'(HOLD_CYCLES - 1);
  localparam logic [19:0] BOUNCE_LD = 20'(BOUNCE_CYCLES - 1);
  localparam logic [19:0] PERIOD_LD = 20'(BOUNCE_PERIOD - 1);
  localparam logic [19:0] GAP_LD    = 20'(GAP_CYCLES - 1);
  localparam bit          NO_BOUNCE = (BOUNCE_CYCLES == 0);

  state_e      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [19:0] tog_q, tog_d;
  logic        contact_q, contact_d;
  logic [1:0]  row_q, row_d;
  logic [2:0]  col_q, col_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  always_ff @(posedge clk5 or negedge rstPBn) begin
    if (!rstPBn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      tog_q     <= '0;
      contact_q <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tog_q     <= tog_d;
      contact_q <= contact_d;
      row_q     <= row_d;
      col_q     <= col_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tog_d     = tog_q;
    contact_d = contact_q;
    row_d     = row_q;
    col_d     = col_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (press_req) begin
          if (press_col > 3'd5) begin
            err_d = 1'b1;
          end else begin
            row_d     = press_row;
            col_d     = press_col;
            contact_d = 1'b1;
            if (NO_BOUNCE) begin
              state_d = S_HOLD;
              cnt_d   = HOLD_LD;
            end else begin
              state_d = S_BOUNCE_IN;
              cnt_d   = BOUNCE_LD;
              tog_d   = PERIOD_LD;
            end
          end
        end
      end
      S_BOUNCE_IN, S_BOUNCE_OUT: begin
        if (cnt_q == '0) begin
          // Bounce ends on the settled level regardless of toggle phase.
          if (state_q == S_BOUNCE_IN) begin
            state_d   = S_HOLD;
            cnt_d     = HOLD_LD;
            contact_d = 1'b1;
          end else begin
            state_d   = S_GAP;
            cnt_d     = GAP_LD;
            contact_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 20'd1;
          if (tog_q == '0) begin
            contact_d = ~contact_q;
            tog_d     = PERIOD_LD;
          end else begin
            tog_d = tog_q - 20'd1;
          end
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          contact_d = 1'b0;
          if (NO_BOUNCE) begin
            state_d = S_GAP;
            cnt_d   = GAP_LD;
          end else begin
            state_d = S_BOUNCE_OUT;
            cnt_d   = BOUNCE_LD;
            tog_d   = PERIOD_LD;
          end
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != S_IDLE);
    done    = done_q;
    err     = err_q;
    contact = contact_q;
    for (int c = 0; c < 6; c++) begin
      kpcol[c] = !(contact_q && !kprow[row_q] && (col_q == 3'(c)));
    end
  end

endmodule
